// File: rtl/logic_gate_unit.sv
// Registered bitwise gate unit with valid/ready handshake and a built-in
// truth-table sweep engine that captures a 32-bit signature of all eight gates.
module logic_gate_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] F_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             sweep_done_o,
    output logic [31:0]      sweep_tt_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSweep = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [4:0] CntLast = 5'd31;

    logic [1:0]       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             valid_q, valid_d;
    logic [31:0]      tt_q, tt_d;

    logic             is_idle;
    logic             accept;
    logic             consume;
    logic             start_go;
    logic             sweep_bit;

    function automatic logic gate_bit(input logic [2:0] op, input logic a, input logic b);
        logic r;
        unique case (op)
            3'd0: r = ~(a & b);
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = ~(a | b);
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: r = ~a;
            3'd7: r = a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = gate_bit(op, a[i], b[i]);
        end
        return r;
    endfunction

    assign is_idle = (state_q == StIdle);
    assign ready_o = is_idle && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;
    assign consume = is_idle && valid_q && ready_i;

    // An operand accepted on the same edge wins over a sweep request, so a
    // sweep never starts with a result pending on the output.
    assign start_go = is_idle && start_i && !valid_q && !accept;

    // Operands are replicated across the word, so bit 0 alone decides the result.
    assign sweep_bit = gate_bit(cnt_q[4:2], cnt_q[0], cnt_q[1]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        valid_d = valid_q;
        tt_d    = tt_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    f_d     = gate_fn(op_i, A_i, B_i);
                    valid_d = 1'b1;
                end else if (consume) begin
                    valid_d = 1'b0;
                end
                if (start_go) begin
                    state_d = StSweep;
                    cnt_d   = 5'd0;
                    tt_d    = 32'd0;
                end
            end
            StSweep: begin
                tt_d[cnt_q] = sweep_bit;
                cnt_d       = cnt_q + 5'd1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            f_q     <= '0;
            valid_q <= 1'b0;
            tt_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            valid_q <= valid_d;
            tt_q    <= tt_d;
        end
    end

    assign F_o          = f_q;
    assign valid_o      = valid_q;
    assign busy_o       = (state_q == StSweep);
    assign sweep_done_o = (state_q == StDone);
    assign sweep_tt_o   = tt_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed handshake and sweep cases
// plus a randomised stream checked through an expected-result queue.
module tb_logic_gate_unit;

    localparam int unsigned WIDTH = 8;
    localparam logic [31:0] GoldenTt = 32'hA5961E87;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b1;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i, b_i;
    logic             valid_i, ready_i, start_i;
    logic             ready_o, valid_o, busy_o, sweep_done_o;
    logic [WIDTH-1:0] f_o;
    logic [31:0]      sweep_tt_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_v;

    logic [7:0] nand_a [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] nand_b [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] nand_f [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] ops_f  [8] = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

    logic_gate_unit #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .op_i         (op_i),
        .A_i          (a_i),
        .B_i          (b_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .F_o          (f_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .sweep_done_o (sweep_done_o),
        .sweep_tt_o   (sweep_tt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0: return ~(a & b);
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Scoreboard: sample the handshake just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (!rst_ni) begin
            sb.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check("sb_spurious_valid", {31'd0, valid_o}, 32'd0);
                end else begin
                    exp_v = sb.pop_front();
                    check("sb_data", {24'd0, f_o}, {24'd0, exp_v});
                end
            end
            if (valid_i && ready_o) sb.push_back(model(op_i, a_i, b_i));
        end
    end

    task automatic run_sweep();
        int  busy_cnt = 0;
        bit  done = 0;
        bit  ready_seen = 0;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        valid_i = 1'b1;
        op_i    = 3'd3;
        a_i     = 8'h5A;
        b_i     = 8'h3C;
        for (int c = 0; c < 40; c++) begin
            if (sweep_done_o) begin
                done = 1;
                break;
            end
            if (busy_o) busy_cnt++;
            if (ready_o) ready_seen = 1;
            @(negedge clk);
        end
        check("sweep_done_seen", {31'd0, done}, 32'd1);
        check("sweep_busy_cycles", busy_cnt, 32'd32);
        check("sweep_ready_low", {31'd0, ready_seen}, 32'd0);
        check("sweep_busy_in_done", {31'd0, busy_o}, 32'd0);
        check("sweep_signature", sweep_tt_o, GoldenTt);
        // start_i during DONE must be ignored
        valid_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("done_pulse_width", {31'd0, sweep_done_o}, 32'd0);
        check("start_in_done_ignored", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        check("start_in_done_ignored2", {31'd0, busy_o}, 32'd0);
        check("sweep_signature_hold", sweep_tt_o, GoldenTt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_i = 3'd0; a_i = '0; b_i = '0;
        valid_i = 1'b0; ready_i = 1'b1; start_i = 1'b0;
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_f", {24'd0, f_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, sweep_done_o}, 32'd0);
        check("rst_tt", sweep_tt_o, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk) rst_ni = 1'b1;

        // NAND over the four canonical patterns, back to back
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; op_i = 3'd0; a_i = nand_a[i]; b_i = nand_b[i];
            @(negedge clk);
            check($sformatf("nand_f%0d", i), {24'd0, f_o}, {24'd0, nand_f[i]});
            check($sformatf("nand_valid%0d", i), {31'd0, valid_o}, 32'd1);
        end
        valid_i = 1'b0;
        @(negedge clk);
        check("nand_drained", {31'd0, valid_o}, 32'd0);

        // All eight ops on F0/CC
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1; op_i = 3'(i); a_i = 8'hF0; b_i = 8'hCC;
            @(negedge clk);
            check($sformatf("op%0d_f", i), {24'd0, f_o}, {24'd0, ops_f[i]});
        end
        valid_i = 1'b0;
        @(negedge clk);

        // Back-pressure
        ready_i = 1'b0; valid_i = 1'b1; op_i = 3'd1; a_i = 8'h0F; b_i = 8'h0F;
        @(negedge clk);
        check("bp_valid", {31'd0, valid_o}, 32'd1);
        check("bp_f", {24'd0, f_o}, 32'h0F);
        op_i = 3'd2; a_i = 8'h33; b_i = 8'h55;
        #1 check("bp_ready_low", {31'd0, ready_o}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_f", {24'd0, f_o}, 32'h0F);
            check("bp_hold_valid", {31'd0, valid_o}, 32'd1);
        end
        ready_i = 1'b1;
        #1 check("bp_ready_back", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        check("bp_swap_f", {24'd0, f_o}, 32'h77);
        check("bp_swap_valid", {31'd0, valid_o}, 32'd1);
        valid_i = 1'b0;
        @(negedge clk);
        check("bp_drained", {31'd0, valid_o}, 32'd0);

        // start_i with a pending result is ignored
        ready_i = 1'b0; valid_i = 1'b1; op_i = 3'd4; a_i = 8'hAA; b_i = 8'h0F;
        @(negedge clk);
        valid_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("start_pending_busy", {31'd0, busy_o}, 32'd0);
        check("start_pending_valid", {31'd0, valid_o}, 32'd1);
        @(negedge clk);
        check("start_pending_busy2", {31'd0, busy_o}, 32'd0);
        ready_i = 1'b1;
        @(negedge clk);
        check("start_pending_drained", {31'd0, valid_o}, 32'd0);

        // Randomised stream with random back-pressure
        for (int i = 0; i < 60; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            op_i    = 3'($urandom_range(0, 7));
            a_i     = 8'($urandom);
            b_i     = 8'($urandom);
            @(negedge clk);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rand_sb_empty", sb.size(), 32'd0);

        // Full sweep
        run_sweep();

        // Asynchronous reset in the middle of a sweep
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_sweep_busy", {31'd0, busy_o}, 32'd1);
        check("mid_sweep_tt", sweep_tt_o, 32'h00000087);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_tt", sweep_tt_o, 32'd0);
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_f", {24'd0, f_o}, 32'd0);
        @(negedge clk) rst_ni = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy_o}, 32'd0);
        run_sweep();

        check("final_sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
Parametrised, registered successor to the single-bit NAND gate. Takes two WIDTH-bit operands through a valid/ready handshake and applies one of eight selectable bitwise gate functions, with 1-cycle registered latency and back-pressure. A built-in sweep engine drives every gate through the four canonical input combinations and captures a 32-bit truth-table signature for self-check.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  reset, asynchronous, active-low
op_i  input  3  gate select: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A
A_i  input  WIDTH  operand A
B_i  input  WIDTH  operand B
valid_i  input  1  upstream operands valid
ready_o  output  1  unit can accept operands this cycle
F_o  output  WIDTH  registered result
valid_o  output  1  F_o holds an unconsumed result
ready_i  input  1  downstream accepts F_o
start_i  input  1  request truth-table sweep
busy_o  output  1  sweep in progress
sweep_done_o  output  1  one-cycle pulse at sweep completion
sweep_tt_o  output  32  captured truth-table signature

Behaviour:
- One clock domain. Reset is asynchronous, active-low (rst_ni). Reset values: F_o=0, valid_o=0, busy_o=0, sweep_done_o=0, sweep_tt_o=0, FSM=IDLE, sweep counter=0.
- Reset asserted mid-sweep or mid-transfer aborts immediately to reset values. Any in-flight result is lost.
- Data path:
  - ready_o = (FSM==IDLE) && (!valid_o || ready_i).
  - Input accept = valid_i && ready_o. On accept, F_o <= f(op_i, A_i, B_i) bitwise and valid_o <= 1 on the same edge, giving latency 1.
  - Output consumed when valid_o && ready_i. If there is no simultaneous accept, valid_o <= 0.
  - Simultaneous consume and accept: F_o is replaced and valid_o stays 1, so full throughput is 1 result per cycle.
  - While valid_o=1 and ready_i=0, F_o and valid_o hold stable.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when start_i=1 && valid_o=0. Otherwise start_i is ignored (not queued). On entry, sweep_tt_o <= 0 and the 5-bit counter cnt <= 0.
  - SWEEP: busy_o=1 and ready_o=0. External operands are ignored, and F_o/valid_o are not touched.
  - Each cycle evaluates op=cnt[4:2] with combination k=cnt[1:0]:
    - k=0: A=0, B=0
    - k=1: A=1, B=0
    - k=2: A=0, B=1
    - k=3: A=1, B=1
  - Operands are replicated across all WIDTH bits. sweep_tt_o[cnt] <= bit 0 of the result, and cnt increments.
  - At cnt==31, the last bit is written and the FSM moves to DONE. A sweep takes exactly 32 cycles.
  - DONE: sweep_done_o=1 for exactly one cycle, busy_o=0, then the FSM returns to IDLE. start_i in DONE is ignored.
  - sweep_tt_o holds its value until the next sweep start or reset.
- Expected signature for a correct unit: 32'hA5961E87. Nibbles op7..op0 are A,5,9,6,1,E,8,7. The NAND nibble is 4'h7.
- All result arithmetic is purely bitwise: no carries, and WIDTH-bit in gives WIDTH-bit out.

Test Plan:
- Reset then NAND sweep of the single-bit pattern: WIDTH=8, op_i=0, ready_i=1, apply A/B = 00/00, FF/00, 00/FF, FF/FF on consecutive cycles -> F_o = FF, FF, FF, 00, each 1 cycle after accept, valid_o continuous.
- All ops with A=8'hF0, B=8'hCC -> F_o for ops 0..7 = 3F, C0, FC, 03, 3C, C3, 0F, F0.
- Back-pressure: ready_i=0 after first accept (A=8'h0F, B=8'h0F, op=1) -> valid_o=1, F_o=0F held, ready_o=0. A second valid_i is not accepted until ready_i=1. Then simultaneous consume+accept keeps valid_o=1 with the new F_o.
- Sweep: start_i pulse with valid_o=0 -> busy_o=1 for 32 cycles, sweep_done_o pulse on cycle 33, sweep_tt_o=32'hA5961E87. ready_o=0 throughout, and valid_i during the sweep is not accepted.
- start_i while valid_o=1 (ready_i=0) -> ignored, busy_o stays 0. start_i in DONE -> ignored.
- Async reset: drop rst_ni at sweep cycle 10 (between clock edges) -> busy_o, sweep_tt_o, valid_o, F_o go to 0 immediately. After release, a new sweep completes with 32'hA5961E87.
